// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: generator state type, 640x480 defaults and
// helpers that derive line/frame totals and counter widths from porch parameters.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  function automatic int h_total(input int disp, input int front, input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  function automatic int v_total(input int disp, input int front, input int sync, input int back);
    return disp + front + sync + back;
  endfunction

  // Bits needed to hold total-1.
  function automatic int cnt_width(input int total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/video_sync_gen_if.sv
// Timing bus between the sync generator (master) and the video cores (slave):
// pixel enable / run request in, raster coordinates, syncs and pulses out.
interface video_sync_gen_if #(
  parameter int H_SIZE = 10,
  parameter int V_SIZE = 10
);
  logic              pix_tick;
  logic              vga_en;
  logic [H_SIZE-1:0] hc;
  logic [V_SIZE-1:0] vc;
  logic              video_on;
  logic              hsync;
  logic              vsync;
  logic              line_start;
  logic              frame_start;
  logic              busy;

  modport master (
    input  pix_tick, vga_en,
    output hc, vc, video_on, hsync, vsync, line_start, frame_start, busy
  );

  modport slave (
    output pix_tick, vga_en,
    input  hc, vc, video_on, hsync, vsync, line_start, frame_start, busy
  );
endinterface

// File: rtl/sync_delay_line.sv
// Enable-gated shift register of configurable depth with a caller-supplied reset
// value; depth 0 is a straight wire. Used for syncs here and suitable for RGB.
module sync_delay_line #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_bypass
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, i_en, i_rst_val};
    assign o_q      = i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= i_rst_val;
      end else if (i_en) begin
        r_stage[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
    end

    assign o_q = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/video_sync_gen.sv
// VGA raster timing generator: registered hc/vc counters, frame-aligned start/stop,
// and hsync/vsync/video_on delayed PIPE_DLY pixel ticks to match video pipelines.
module video_sync_gen
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter int SYNC_POL  = 0,
  parameter int PIPE_DLY  = 1
) (
  input logic              clk,
  input logic              rst,
  video_sync_gen_if.master bus
);

  localparam int H_TOTAL = h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int H_SIZE  = cnt_width(H_TOTAL);
  localparam int V_SIZE  = cnt_width(V_TOTAL);

  localparam logic [H_SIZE-1:0] H_LAST   = H_SIZE'(H_TOTAL - 1);
  localparam logic [H_SIZE-1:0] H_VIS    = H_SIZE'(H_DISPLAY);
  localparam logic [H_SIZE-1:0] HS_FIRST = H_SIZE'(H_DISPLAY + H_FRONT);
  localparam logic [H_SIZE-1:0] HS_LAST  = H_SIZE'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [V_SIZE-1:0] V_LAST   = V_SIZE'(V_TOTAL - 1);
  localparam logic [V_SIZE-1:0] V_VIS    = V_SIZE'(V_DISPLAY);
  localparam logic [V_SIZE-1:0] VS_FIRST = V_SIZE'(V_DISPLAY + V_FRONT);
  localparam logic [V_SIZE-1:0] VS_LAST  = V_SIZE'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  localparam logic SYNC_ACT   = (SYNC_POL != 0);
  localparam logic SYNC_INACT = ~SYNC_ACT;

  state_e            r_state, w_state_next;
  logic [H_SIZE-1:0] r_hc, w_hc_next;
  logic [V_SIZE-1:0] r_vc, w_vc_next;
  logic              r_line_start, w_line_start_next;
  logic              r_frame_start, w_frame_start_next;

  logic w_h_last, w_v_last, w_active;
  logic w_video_on, w_hs_act, w_vs_act, w_hsync, w_vsync;
  logic [2:0] w_dly_d, w_dly_q, w_dly_rst;

  assign w_h_last = (r_hc == H_LAST);
  assign w_v_last = (r_vc == V_LAST);
  assign w_active = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_hc          <= '0;
      r_vc          <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_hc          <= w_hc_next;
      r_vc          <= w_vc_next;
      r_line_start  <= w_line_start_next;
      r_frame_start <= w_frame_start_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_hc_next          = r_hc;
    w_vc_next          = r_vc;
    w_line_start_next  = 1'b0;
    w_frame_start_next = 1'b0;

    case (r_state)
      IDLE: begin
        w_hc_next = '0;
        w_vc_next = '0;
        // The starting tick is consumed by the transition, so (0,0) is shown first.
        if (bus.vga_en && bus.pix_tick) begin
          w_state_next       = RUN;
          w_line_start_next  = 1'b1;
          w_frame_start_next = 1'b1;
        end
      end

      RUN, DRAIN: begin
        w_state_next = bus.vga_en ? RUN : DRAIN;
        if (bus.pix_tick) begin
          // Stopping is only honoured on the last pixel of a frame.
          if (w_h_last && w_v_last && !bus.vga_en) begin
            w_state_next = IDLE;
            w_hc_next    = '0;
            w_vc_next    = '0;
          end else if (w_h_last) begin
            w_hc_next          = '0;
            w_vc_next          = w_v_last ? '0 : r_vc + 1'b1;
            w_line_start_next  = 1'b1;
            w_frame_start_next = w_v_last;
          end else begin
            w_hc_next = r_hc + 1'b1;
          end
        end
      end

      default: begin
        w_state_next = IDLE;
        w_hc_next    = '0;
        w_vc_next    = '0;
      end
    endcase
  end

  assign w_video_on = w_active && (r_hc < H_VIS) && (r_vc < V_VIS);
  assign w_hs_act   = w_active && (r_hc >= HS_FIRST) && (r_hc <= HS_LAST);
  assign w_vs_act   = w_active && (r_vc >= VS_FIRST) && (r_vc <= VS_LAST);
  assign w_hsync    = w_hs_act ? SYNC_ACT : SYNC_INACT;
  assign w_vsync    = w_vs_act ? SYNC_ACT : SYNC_INACT;

  assign w_dly_d   = {w_video_on, w_hsync, w_vsync};
  assign w_dly_rst = {1'b0, SYNC_INACT, SYNC_INACT};

  sync_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_DLY)
  ) u_sync_dly (
    .clk       (clk),
    .rst       (rst),
    .i_en      (bus.pix_tick),
    .i_rst_val (w_dly_rst),
    .i_d       (w_dly_d),
    .o_q       (w_dly_q)
  );

  assign bus.hc          = r_hc;
  assign bus.vc          = r_vc;
  assign bus.video_on    = w_dly_q[2];
  assign bus.hsync       = w_dly_q[1];
  assign bus.vsync       = w_dly_q[0];
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;
  assign bus.busy        = w_active;

endmodule

// File: tb/tb_video_sync_gen.sv
// Bench for video_sync_gen on a 16x8 raster: DUT a has no sync delay and a full-rate
// tick, DUT b has a 2-tick delay and a slower tick; both follow a raster-position model.
module tb_video_sync_gen;

  localparam int HD = 8, HF = 2, HS = 3, HB = 3;
  localparam int VD = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  video_sync_gen_if #(.H_SIZE(4), .V_SIZE(3)) bus_a ();
  video_sync_gen_if #(.H_SIZE(4), .V_SIZE(3)) bus_b ();

  video_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(0), .PIPE_DLY(0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  video_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(0), .PIPE_DLY(2)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit ph      = 1'b0;

  // Model: a generator is either stopped or sitting at raster position pos = vc*HT+hc.
  int       m_dly    [2] = '{0, 2};
  bit       m_active [2];
  int       m_pos    [2];
  bit       m_ls     [2];
  bit       m_fs     [2];
  bit [2:0] m_pipe   [2][4];

  function automatic bit [2:0] m_raw(input int k);
    int h, v;
    if (!m_active[k]) return 3'b000;
    h = m_pos[k] % HT;
    v = m_pos[k] / HT;
    return {h < HD && v < VD,
            h >= HD + HF && h < HD + HF + HS,
            v >= VD + VF && v < VD + VF + VS};
  endfunction

  task automatic m_step(input int k, input bit tick, input bit en, input bit r);
    bit [2:0] raw;
    if (r) begin
      m_active[k] = 1'b0;
      m_pos[k]    = 0;
      m_ls[k]     = 1'b0;
      m_fs[k]     = 1'b0;
      for (int i = 0; i < 4; i++) m_pipe[k][i] = 3'b000;
      return;
    end
    raw     = m_raw(k);
    m_ls[k] = 1'b0;
    m_fs[k] = 1'b0;
    if (tick) begin
      for (int i = 3; i > 0; i--) m_pipe[k][i] = m_pipe[k][i-1];
      m_pipe[k][0] = raw;
    end
    if (!m_active[k]) begin
      if (en && tick) begin
        m_active[k] = 1'b1;
        m_pos[k]    = 0;
        m_ls[k]     = 1'b1;
        m_fs[k]     = 1'b1;
      end
    end else if (tick) begin
      if (m_pos[k] == FRAME - 1 && !en) begin
        m_active[k] = 1'b0;
        m_pos[k]    = 0;
      end else begin
        m_pos[k] = (m_pos[k] + 1) % FRAME;
        if (m_pos[k] % HT == 0) m_ls[k] = 1'b1;
        if (m_pos[k] == 0)      m_fs[k] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      bit [2:0] d;
      string    p;
      p = (k == 0) ? "a" : "b";
      d = (m_dly[k] == 0) ? m_raw(k) : m_pipe[k][m_dly[k]-1];
      chk({p, ".hc"},          32'((k == 0) ? bus_a.hc : bus_b.hc),                   32'(m_pos[k] % HT));
      chk({p, ".vc"},          32'((k == 0) ? bus_a.vc : bus_b.vc),                   32'(m_pos[k] / HT));
      chk({p, ".busy"},        32'((k == 0) ? bus_a.busy : bus_b.busy),               32'(m_active[k]));
      chk({p, ".line_start"},  32'((k == 0) ? bus_a.line_start : bus_b.line_start),   32'(m_ls[k]));
      chk({p, ".frame_start"}, 32'((k == 0) ? bus_a.frame_start : bus_b.frame_start), 32'(m_fs[k]));
      chk({p, ".video_on"},    32'((k == 0) ? bus_a.video_on : bus_b.video_on),       32'(d[2]));
      chk({p, ".hsync"},       32'((k == 0) ? bus_a.hsync : bus_b.hsync),             32'(!d[1]));
      chk({p, ".vsync"},       32'((k == 0) ? bus_a.vsync : bus_b.vsync),             32'(!d[0]));
    end
  endtask

  // Called at a negedge: drive inputs, let one posedge happen, check at the next negedge.
  task automatic cycle(input bit tick_a, input bit tick_b, input bit en, input bit r);
    bus_a.pix_tick = tick_a;
    bus_b.pix_tick = tick_b;
    bus_a.vga_en   = en;
    bus_b.vga_en   = en;
    rst            = r;
    @(posedge clk);
    m_step(0, tick_a, en, r);
    m_step(1, tick_b, en, r);
    @(negedge clk);
    cyc++;
    ph = ~ph;
    check_outputs();
  endtask

  initial begin
    int von_cnt;
    int fs_cyc;
    bit got;
    bit en_r;

    bus_a.pix_tick = 1'b0;
    bus_b.pix_tick = 1'b0;
    bus_a.vga_en   = 1'b0;
    bus_b.vga_en   = 1'b0;
    rst            = 1'b1;
    @(negedge clk);

    // Reset, then idle with ticks but no request.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1);
    chk("reset_hsync", 32'(bus_a.hsync), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, ph, 1'b0, 1'b0);

    // Start: busy, frame_start and line_start together with (0,0).
    cycle(1'b1, ph, 1'b1, 1'b0);
    chk("start_busy", 32'(bus_a.busy), 32'd1);
    chk("start_frame_start", 32'(bus_a.frame_start), 32'd1);

    // One whole frame: 32 visible pixels, next frame_start 128 clks later.
    von_cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      von_cnt += int'(bus_a.video_on);
      cycle(1'b1, ph, 1'b1, 1'b0);
    end
    chk("video_on_per_frame", 32'(von_cnt), 32'd32);
    chk("frame_period", 32'(bus_a.frame_start), 32'd1);

    // Drop the request at (3,2): run out the frame and stop cleanly.
    for (int i = 0; i < 300 && m_pos[0] != 2 * HT + 3; i++) cycle(1'b1, ph, 1'b1, 1'b0);
    chk("reach_3_2", 32'(m_pos[0]), 32'(2 * HT + 3));
    for (int i = 0; i < 300 && m_active[0]; i++) cycle(1'b1, ph, 1'b0, 1'b0);
    chk("drain_stopped", 32'(bus_a.busy), 32'd0);
    for (int i = 0; i < 300 && m_active[1]; i++) cycle(1'b1, ph, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, ph, 1'b0, 1'b0);

    // Drop then re-raise during drain: frame cadence must be untouched.
    cycle(1'b1, ph, 1'b1, 1'b0);
    fs_cyc = cyc;
    for (int i = 0; i < 60; i++) cycle(1'b1, ph, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, ph, 1'b0, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      cycle(1'b1, ph, 1'b1, 1'b0);
      if (bus_a.frame_start === 1'b1) got = 1'b1;
    end
    chk("reraise_frame_start_seen", 32'(got), 32'd1);
    chk("reraise_frame_period", 32'(cyc - fs_cyc), 32'(FRAME));

    // Randomised ticks, requests and occasional resets.
    en_r = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) == 0) en_r = ~en_r;
      cycle(($urandom_range(0, 3) != 0), 1'($urandom), en_r, ($urandom_range(0, 799) == 0));
    end

    // Reset mid-frame while both syncs are active.
    for (int i = 0; i < 300 && !(m_active[0] && m_pos[0] == 6 * HT + 11); i++)
      cycle(1'b1, ph, 1'b1, 1'b0);
    chk("pre_rst_hsync_active", 32'(bus_a.hsync), 32'd0);
    cycle(1'b1, ph, 1'b1, 1'b1);
    chk("rst_hsync", 32'(bus_a.hsync), 32'd1);
    chk("rst_vsync", 32'(bus_a.vsync), 32'd1);
    chk("rst_busy", 32'(bus_b.busy), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, ph, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/video_sync_gen.md
Name: video_sync_gen

Overview:
- Timing generator that drives the `hc`/`vc` pixel coordinates consumed by the video cores (bar, sprite, text) and produces the matching VGA sync signals.
- Free-running horizontal/vertical counters advance on a pixel tick.
- hsync/vsync/video_on are delayed by a programmable number of pixels so they line up with registered video-core pipelines.
- A start/stop state machine guarantees output only ever begins and ends on frame boundaries.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- PIPE_DLY, 1, pixel-tick delay applied to hsync/vsync/video_on (0..4)

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- pix_tick  input  1  pixel enable; counters and delay line advance only when 1
- vga_en  input  1  request to run timing
- hc  output  `H_SIZE  horizontal count, registered
- vc  output  `V_SIZE  vertical count, registered
- video_on  output  1  hc<H_DISPLAY && vc<V_DISPLAY, delayed PIPE_DLY ticks
- hsync  output  1  delayed PIPE_DLY ticks
- vsync  output  1  delayed PIPE_DLY ticks
- line_start  output  1  one-clk pulse, first clk with hc==0 of each line
- frame_start  output  1  one-clk pulse, first clk with hc==0,vc==0 of each frame
- busy  output  1  state != IDLE

Behaviour:
- Derived totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. The team's `vga.svh` must size `H_SIZE`/`V_SIZE` to hold H_TOTAL-1 and V_TOTAL-1.
- Reset values (rst=1 at a clk edge):
  - state=IDLE; hc=0; vc=0
  - video_on=0; line_start=0; frame_start=0; busy=0
  - hsync=vsync=~SYNC_POL
  - every delay-line stage reset to these inactive values
- A reset asserted mid-frame aborts immediately; there is no drain.
- States:
  - IDLE: counters held at 0; undelayed syncs inactive; video_on=0.
    - Transition to RUN on the first clk with vga_en=1 && pix_tick=1.
    - That tick does not advance the counters: (0,0) is the first pixel.
    - frame_start and line_start pulse in the following clk.
  - RUN: counters run.
    - vga_en=0 → DRAIN.
  - DRAIN: counters keep running.
    - On pix_tick with hc==H_TOTAL-1 && vc==V_TOTAL-1: go to IDLE, counters to 0, no frame_start.
    - vga_en=1 while in DRAIN → back to RUN with no timing disturbance.
    - If vga_en drops exactly on the last pixel of a frame, go directly to IDLE.
- Counting (RUN/DRAIN, pix_tick=1):
  - hc==H_TOTAL-1 → hc=0 and vc increments.
  - vc==V_TOTAL-1 at that point → vc=0.
  - Otherwise hc increments.
- Sync generation:
  - Undelayed hsync active when H_DISPLAY+H_FRONT ≤ hc ≤ H_DISPLAY+H_FRONT+H_SYNC-1.
  - vsync uses the same rule on vc with V_* parameters.
- Delay line:
  - PIPE_DLY-deep shift register of {video_on,hsync,vsync}; shifts only on pix_tick.
  - PIPE_DLY=0: outputs are combinational from hc/vc.
- Pulses:
  - line_start/frame_start are registered and last exactly one clk regardless of pix_tick rate.
  - Never asserted in IDLE.
- pix_tick=0: all outputs hold; pulses deassert after one clk.

Decomposition:
- Shared package `vga_pkg`:
  - state enum {IDLE, RUN, DRAIN}
  - functions computing H_TOTAL/V_TOTAL
  - default 640x480 timing constants (alongside `vga.svh` macros)
- One sub-module, `sync_delay_line`: parameterised-depth, enable-gated shift register with reset value input. Also reusable for delaying RGB.

Test Plan:
Small config for all scenarios: H_DISPLAY=8, H_FRONT=2, H_SYNC=3, H_BACK=3 (H_TOTAL=16); V 4/1/2/1 (V_TOTAL=8); pix_tick every clk; PIPE_DLY=0 unless stated.
- Reset then vga_en=1 → busy=1 next clk; frame_start and line_start pulse with hc=0, vc=0; hc reaches 15 then wraps to 0 while vc goes 0→1.
- Full frame → hsync low exactly for hc 10..12; vsync low exactly for vc 5..6; video_on=1 for exactly 32 pixels per frame; frame period 128 clks.
- vga_en dropped at hc=3, vc=2 → counting continues to (15,7), then IDLE: hc=vc=0, busy=0, no further frame_start.
- vga_en dropped then re-raised during DRAIN → no gap; next frame_start exactly 128 clks after the previous one.
- PIPE_DLY=2 with pix_tick 1-in-2 → hsync falls 2 ticks (4 clks) after hc becomes 10; hc/vc hold on non-tick clks; line_start width 1 clk.
- rst asserted at hc=11, vc=6 (hsync and vsync active) → next clk all outputs at reset values: hsync=vsync=1, hc=vc=0, busy=0.
